// File: rtl/vga_timing_pkg.sv
// Shared raster timing for the Pong display path: 640x480@60 defaults,
// derived totals, sync window positions and the per-axis phase encoding.
package vga_timing_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   localparam logic SYNC_ACTIVE_DEFAULT = 1'b0;
   localparam int   CNT_W               = 10;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_t;

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Outputs are registered from the next-state values so count, phase and
// sync always describe the same position. The next-state values are also
// exported so the top can register further decodes in the same alignment.
module vga_axis_timer
   import vga_timing_pkg::*;
#(
   parameter int   VISIBLE     = 640,
   parameter int   FRONT       = 16,
   parameter int   SYNC        = 96,
   parameter int   BACK        = 48,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                advance,
   output logic [CNT_W-1:0]    count,
   output phase_t              phase,
   output logic                wrap,
   output logic                sync,
   output logic [CNT_W-1:0]    next_count,
   output phase_t              next_phase
);

   localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;

   // A total that does not fit the 10-bit counter cannot be represented.
   if (TOTAL > 1023) begin : g_width_check
      $fatal(1, "vga_axis_timer: axis total %0d exceeds 10-bit range", TOTAL);
   end

   localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] FRONT_AT = CNT_W'(VISIBLE);
   localparam logic [CNT_W-1:0] SYNC_AT  = CNT_W'(VISIBLE + FRONT);
   localparam logic [CNT_W-1:0] BACK_AT  = CNT_W'(VISIBLE + FRONT + SYNC);

   // Terminal count: the next advance returns the axis to zero.
   assign wrap = (count == LAST);

   // Next counter value: hold unless advancing, wrap at the last position.
   always_comb begin
      next_count = count;
      if (advance) begin
         next_count = wrap ? '0 : count + CNT_W'(1);
      end
   end

   // Phase transitions fire when the next count reaches each threshold.
   always_comb begin
      next_phase = phase;
      if (advance) begin
         case (phase)
            PH_ACTIVE: if (next_count == FRONT_AT) next_phase = PH_FRONT;
            PH_FRONT:  if (next_count == SYNC_AT)  next_phase = PH_SYNC;
            PH_SYNC:   if (next_count == BACK_AT)  next_phase = PH_BACK;
            PH_BACK:   if (next_count == '0)       next_phase = PH_ACTIVE;
            default:   next_phase = PH_ACTIVE;
         endcase
      end
   end

   // State register; reset lands on position 0, which is ACTIVE with sync idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         phase <= PH_ACTIVE;
         sync  <= ~SYNC_ACTIVE;
      end else begin
         count <= next_count;
         phase <= next_phase;
         sync  <= (next_phase == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster source for the Pong display: x/y position, h/v sync, active flag,
// line/frame strobes and a frame counter used as the game tick. Every output
// is a register decoded from next-state counters, so all of them line up
// with the x/y presented in the same cycle.
module vga_sync_gen #(
   parameter int   H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
   parameter int   H_FRONT     = vga_timing_pkg::H_FRONT,
   parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
   parameter int   H_BACK      = vga_timing_pkg::H_BACK,
   parameter int   V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
   parameter int   V_FRONT     = vga_timing_pkg::V_FRONT,
   parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
   parameter int   V_BACK      = vga_timing_pkg::V_BACK,
   parameter logic SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE_DEFAULT
) (
   input  logic                     i_CLK,
   input  logic                     i_RST,
   input  logic                     i_pix_en,
   output logic [9:0]               o_display_x_pos,
   output logic [9:0]               o_display_y_pos,
   output logic                     o_hSync,
   output logic                     o_vSync,
   output logic                     o_active,
   output logic                     o_line_start,
   output logic                     o_frame_start,
   output logic [7:0]               o_frame_count,
   output vga_timing_pkg::phase_t   h_phase,
   output vga_timing_pkg::phase_t   v_phase
);

   import vga_timing_pkg::*;

   logic            h_wrap;
   logic            v_wrap;
   logic            v_advance;
   logic [CNT_W-1:0] h_next_count;
   logic [CNT_W-1:0] v_next_count;
   phase_t          h_next_phase;
   phase_t          v_next_phase;

   // The vertical axis steps on the edge where x wraps to 0.
   assign v_advance = i_pix_en & h_wrap;

   vga_axis_timer #(
      .VISIBLE     (H_VISIBLE),
      .FRONT       (H_FRONT),
      .SYNC        (H_SYNC),
      .BACK        (H_BACK),
      .SYNC_ACTIVE (SYNC_ACTIVE)
   ) u_h_axis (
      .clk        (i_CLK),
      .rst        (i_RST),
      .advance    (i_pix_en),
      .count      (o_display_x_pos),
      .phase      (h_phase),
      .wrap       (h_wrap),
      .sync       (o_hSync),
      .next_count (h_next_count),
      .next_phase (h_next_phase)
   );

   vga_axis_timer #(
      .VISIBLE     (V_VISIBLE),
      .FRONT       (V_FRONT),
      .SYNC        (V_SYNC),
      .BACK        (V_BACK),
      .SYNC_ACTIVE (SYNC_ACTIVE)
   ) u_v_axis (
      .clk        (i_CLK),
      .rst        (i_RST),
      .advance    (v_advance),
      .count      (o_display_y_pos),
      .phase      (v_phase),
      .wrap       (v_wrap),
      .sync       (o_vSync),
      .next_count (v_next_count),
      .next_phase (v_next_phase)
   );

   // Registered area/strobe decodes and the frame tick; reset equals the (0,0) decode.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         o_active      <= 1'b1;
         o_line_start  <= 1'b1;
         o_frame_start <= 1'b1;
         o_frame_count <= '0;
      end else begin
         o_active      <= (h_next_phase == PH_ACTIVE) && (v_next_phase == PH_ACTIVE);
         o_line_start  <= (h_next_count == '0);
         o_frame_start <= (h_next_count == '0) && (v_next_count == '0);
         if (v_advance && v_wrap) begin
            o_frame_count <= o_frame_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen. One instance uses the 640-pixel line with
// a shortened vertical axis (4/2/2/2 lines, vsync on lines 6..7) so whole
// frames fit the run; a second, tiny instance (16x8 raster, positive sync)
// covers inverted sync levels and the 8-bit frame counter wrap.
module tb_vga_sync_gen;
   import vga_timing_pkg::*;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // Large-line instance
   logic       rst, pix_en;
   logic [9:0] x, y;
   logic       hs, vs, act, ls, fs;
   logic [7:0] fc;
   phase_t     hph, vph;

   // Tiny instance
   logic       rst_s, pix_en_s;
   logic [9:0] x_s, y_s;
   logic       hs_s, vs_s, act_s, ls_s, fs_s;
   logic [7:0] fc_s;
   phase_t     hph_s, vph_s;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference positions (large: 800 x 10, tiny: 16 x 8)
   int ex = 0, ey = 0, efc = 0;
   int sx = 0, sy = 0, sfc = 0;

   vga_sync_gen #(
      .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
   ) dut (
      .i_CLK(clk), .i_RST(rst), .i_pix_en(pix_en),
      .o_display_x_pos(x), .o_display_y_pos(y),
      .o_hSync(hs), .o_vSync(vs), .o_active(act),
      .o_line_start(ls), .o_frame_start(fs), .o_frame_count(fc),
      .h_phase(hph), .v_phase(vph)
   );

   vga_sync_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .SYNC_ACTIVE(1'b1)
   ) dut_s (
      .i_CLK(clk), .i_RST(rst_s), .i_pix_en(pix_en_s),
      .o_display_x_pos(x_s), .o_display_y_pos(y_s),
      .o_hSync(hs_s), .o_vSync(vs_s), .o_active(act_s),
      .o_line_start(ls_s), .o_frame_start(fs_s), .o_frame_count(fc_s),
      .h_phase(hph_s), .v_phase(vph_s)
   );

   // One clock; inputs are only changed after this returns, so the values
   // read here are the ones the DUT saw on the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (rst) begin
         ex = 0; ey = 0; efc = 0;
      end else if (pix_en) begin
         if (ex == 799) begin
            ex = 0;
            if (ey == 9) begin ey = 0; efc = (efc + 1) % 256; end
            else ey = ey + 1;
         end else ex = ex + 1;
      end
      if (rst_s) begin
         sx = 0; sy = 0; sfc = 0;
      end else if (pix_en_s) begin
         if (sx == 15) begin
            sx = 0;
            if (sy == 7) begin sy = 0; sfc = (sfc + 1) % 256; end
            else sy = sy + 1;
         end else sx = sx + 1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; pix_en = 1'b1;
      tick(); tick();
      n_cmp++; if (x !== 10'd0)  begin n_bad++; $display("FAIL reset_x: got %0d want 0", x); end
      n_cmp++; if (y !== 10'd0)  begin n_bad++; $display("FAIL reset_y: got %0d want 0", y); end
      n_cmp++; if (hs !== 1'b1)  begin n_bad++; $display("FAIL reset_hsync: got %b want 1", hs); end
      n_cmp++; if (vs !== 1'b1)  begin n_bad++; $display("FAIL reset_vsync: got %b want 1", vs); end
      n_cmp++; if (act !== 1'b1) begin n_bad++; $display("FAIL reset_active: got %b want 1", act); end
      n_cmp++; if (ls !== 1'b1)  begin n_bad++; $display("FAIL reset_line_start: got %b want 1", ls); end
      n_cmp++; if (fs !== 1'b1)  begin n_bad++; $display("FAIL reset_frame_start: got %b want 1", fs); end
      n_cmp++; if (fc !== 8'd0)  begin n_bad++; $display("FAIL reset_frame_count: got %0d want 0", fc); end
      n_cmp++; if (hph !== PH_ACTIVE) begin n_bad++; $display("FAIL reset_h_phase: got %0d want 0", hph); end
      rst = 1'b0;
      tick();
      n_cmp++; if (x !== 10'd1 || ls !== 1'b0 || fs !== 1'b0) begin
         n_bad++; $display("FAIL first_step: got x=%0d ls=%b fs=%b want x=1 ls=0 fs=0", x, ls, fs);
      end
   endtask

   task automatic test_active_boundary();
      repeat (638) tick();
      n_cmp++; if (x !== 10'd639 || act !== 1'b1) begin
         n_bad++; $display("FAIL active_639: got x=%0d act=%b want x=639 act=1", x, act);
      end
      tick();
      n_cmp++; if (x !== 10'd640 || act !== 1'b0) begin
         n_bad++; $display("FAIL active_640: got x=%0d act=%b want x=640 act=0", x, act);
      end
   endtask

   task automatic test_hsync_line();
      int lows = 0;
      int errs = 0;
      for (int i = 0; i < 159; i++) begin
         tick();
         if (hs === 1'b0) lows++;
         if (x !== 10'(ex) || hs !== ((ex >= 656 && ex <= 751) ? 1'b0 : 1'b1)) errs++;
      end
      n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL hsync_window: got %0d bad cycles want 0", errs); end
      n_cmp++; if (lows != 96) begin n_bad++; $display("FAIL hsync_width: got %0d want 96", lows); end
      n_cmp++; if (x !== 10'd799 || y !== 10'd0) begin
         n_bad++; $display("FAIL line_end: got x=%0d y=%0d want 799,0", x, y);
      end
      tick();
      n_cmp++; if (x !== 10'd0 || y !== 10'd1 || ls !== 1'b1 || fs !== 1'b0 || act !== 1'b1) begin
         n_bad++; $display("FAIL line_wrap: got x=%0d y=%0d ls=%b fs=%b act=%b want 0,1,1,0,1", x, y, ls, fs, act);
      end
   endtask

   task automatic test_frame();
      int lows = 0;
      int errs = 0;
      int fc_before = -1;
      bit done = 1'b0;
      for (int i = 0; i < 8000 && !done; i++) begin
         tick();
         if (vs === 1'b0) lows++;
         if (x !== 10'(ex) || y !== 10'(ey) ||
             vs !== ((ey == 6 || ey == 7) ? 1'b0 : 1'b1) ||
             act !== (ex < 640 && ey < 4) ||
             fs !== (ex == 0 && ey == 0)) errs++;
         if (ex == 799 && ey == 9) fc_before = int'(fc);
         if (ex == 0 && ey == 0) done = 1'b1;
      end
      n_cmp++; if (!done) begin n_bad++; $display("FAIL frame_timeout: got no frame wrap want wrap within 8000"); end
      n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL frame_decode: got %0d bad cycles want 0", errs); end
      n_cmp++; if (lows != 1600) begin n_bad++; $display("FAIL vsync_width: got %0d want 1600", lows); end
      n_cmp++; if (fc_before != 0) begin n_bad++; $display("FAIL frame_count_pre: got %0d want 0", fc_before); end
      n_cmp++; if (x !== 10'd0 || y !== 10'd0 || fs !== 1'b1 || fc !== 8'd1) begin
         n_bad++; $display("FAIL frame_wrap: got x=%0d y=%0d fs=%b fc=%0d want 0,0,1,1", x, y, fs, fc);
      end
   endtask

   task automatic test_pix_en_freeze();
      repeat (655) tick();
      n_cmp++; if (x !== 10'd655 || hs !== 1'b1) begin
         n_bad++; $display("FAIL pre_freeze: got x=%0d hs=%b want 655,1", x, hs);
      end
      pix_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (x !== 10'd655 || y !== 10'd0 || hs !== 1'b1 || ls !== 1'b0 || fc !== 8'd1) begin
            n_bad++; $display("FAIL frozen: got x=%0d y=%0d hs=%b ls=%b fc=%0d want 655,0,1,0,1", x, y, hs, ls, fc);
         end
      end
      pix_en = 1'b1;
      tick();
      n_cmp++; if (x !== 10'd656 || hs !== 1'b0) begin
         n_bad++; $display("FAIL resume: got x=%0d hs=%b want 656,0", x, hs);
      end
   endtask

   task automatic test_reset_mid_frame();
      repeat (7 * 800 + 44) tick();
      n_cmp++; if (x !== 10'd700 || y !== 10'd7 || hs !== 1'b0 || vs !== 1'b0 || fc !== 8'd1) begin
         n_bad++; $display("FAIL pre_reset: got x=%0d y=%0d hs=%b vs=%b fc=%0d want 700,7,0,0,1", x, y, hs, vs, fc);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (x !== 10'd0 || y !== 10'd0 || hs !== 1'b1 || vs !== 1'b1 || fc !== 8'd0 || fs !== 1'b1 || act !== 1'b1) begin
         n_bad++; $display("FAIL mid_reset: got x=%0d y=%0d hs=%b vs=%b fc=%0d fs=%b act=%b want 0,0,1,1,0,1,1",
                           x, y, hs, vs, fc, fs, act);
      end
      tick();
      n_cmp++; if (x !== 10'd1 || y !== 10'd0 || fs !== 1'b0) begin
         n_bad++; $display("FAIL post_reset: got x=%0d y=%0d fs=%b want 1,0,0", x, y, fs);
      end
   endtask

   task automatic test_inverted_sync();
      int hs_hi = 0;
      int vs_hi = 0;
      int errs = 0;
      rst_s = 1'b1; pix_en_s = 1'b1;
      tick();
      rst_s = 1'b0;
      n_cmp++; if (hs_s !== 1'b0 || vs_s !== 1'b0 || fs_s !== 1'b1 || x_s !== 10'd0) begin
         n_bad++; $display("FAIL inv_reset: got hs=%b vs=%b fs=%b x=%0d want 0,0,1,0", hs_s, vs_s, fs_s, x_s);
      end
      for (int i = 0; i < 128; i++) begin
         tick();
         if (hs_s === 1'b1) hs_hi++;
         if (vs_s === 1'b1) vs_hi++;
         if (x_s !== 10'(sx) || y_s !== 10'(sy) ||
             hs_s !== (sx >= 10 && sx <= 12) ||
             vs_s !== (sy == 5 || sy == 6) ||
             act_s !== (sx < 8 && sy < 4) ||
             ls_s !== (sx == 0)) errs++;
      end
      n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL inv_decode: got %0d bad cycles want 0", errs); end
      n_cmp++; if (hs_hi != 24) begin n_bad++; $display("FAIL inv_hsync_count: got %0d want 24", hs_hi); end
      n_cmp++; if (vs_hi != 32) begin n_bad++; $display("FAIL inv_vsync_count: got %0d want 32", vs_hi); end
      n_cmp++; if (fc_s !== 8'd1 || x_s !== 10'd0 || y_s !== 10'd0) begin
         n_bad++; $display("FAIL inv_frame: got fc=%0d x=%0d y=%0d want 1,0,0", fc_s, x_s, y_s);
      end
   endtask

   task automatic test_frame_count_wrap();
      bit hit = 1'b0;
      for (int i = 0; i < 40000 && !hit; i++) begin
         tick();
         if (sfc == 255 && sx == 15 && sy == 7) hit = 1'b1;
      end
      n_cmp++; if (!hit || fc_s !== 8'd255) begin
         n_bad++; $display("FAIL fc_255: got fc=%0d reached=%0d want 255", fc_s, hit);
      end
      tick();
      n_cmp++; if (fc_s !== 8'd0 || x_s !== 10'd0 || y_s !== 10'd0 || fs_s !== 1'b1) begin
         n_bad++; $display("FAIL fc_wrap: got fc=%0d x=%0d y=%0d fs=%b want 0,0,0,1", fc_s, x_s, y_s, fs_s);
      end
   endtask

   initial begin
      rst = 1'b1; pix_en = 1'b1;
      rst_s = 1'b1; pix_en_s = 1'b1;
      test_reset();
      test_active_boundary();
      test_hsync_line();
      test_frame();
      test_pix_en_freeze();
      test_reset_mid_frame();
      test_inverted_sync();
      test_frame_count_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
